// File: rtl/chrono_core.sv
// chrono_core: BCD stopwatch with debounced push-buttons, active-low seven-segment digits and status LEDs.
// Define CHRONO_LAP_EN to build the lap-freeze state, snapshot register and btn_lap conditioning.

module chrono_core #(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned TICK_HZ         = 100,
  parameter int unsigned N_DIGITS        = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_start,
  input  logic                  btn_lap,
  input  logic                  btn_clear,
  output logic [7*N_DIGITS-1:0] seg,
  output logic [2:0]            leds
);

  localparam int unsigned PRESCALE = CLK_HZ / TICK_HZ;
  localparam int unsigned PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

`ifdef CHRONO_LAP_EN
  localparam int unsigned N_BTN = 3;
`else
  localparam int unsigned N_BTN = 2;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_LAP
  } state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic [N_BTN-1:0]         raw_c;
  logic [N_BTN-1:0]         sync1_q;
  logic [N_BTN-1:0]         sync2_q;
  logic [N_BTN-1:0]         level_q;
  logic [N_BTN-1:0]         level_d1_q;
  logic [N_BTN-1:0]         press_q;
  logic [N_BTN-1:0][DB_W-1:0] db_cnt_q;
  logic                     start_p;
  logic                     clear_p;
  logic                     running_c;
  logic                     lap_act_c;
  logic                     tick_c;
  logic                     all_max_c;
  logic [PSC_W-1:0]         psc_q;
  logic [N_DIGITS-1:0][3:0] cnt_q;
  logic [N_DIGITS-1:0][3:0] cnt_inc_c;
  logic [N_DIGITS-1:0][3:0] disp_c;
  logic                     ovf_q;

`ifdef CHRONO_LAP_EN
  logic                     lap_p;
  logic                     snap_take_c;
  logic [N_DIGITS-1:0][3:0] snap_q;

  assign raw_c = {btn_lap, btn_clear, btn_start};
  assign lap_p = press_q[2];
`else
  logic lap_unused;

  assign raw_c      = {btn_clear, btn_start};
  assign lap_unused = btn_lap;
`endif

  assign start_p = press_q[0];
  assign clear_p = press_q[1];

  // Per-button synchroniser, stability counter and registered rising-edge pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      level_q    <= '0;
      level_d1_q <= '0;
      press_q    <= '0;
      db_cnt_q   <= '0;
    end else begin
      sync1_q    <= raw_c;
      sync2_q    <= sync1_q;
      level_d1_q <= level_q;
      press_q    <= level_q & ~level_d1_q;
      for (int b = 0; b < int'(N_BTN); b++) begin
        if (sync2_q[b] == level_q[b]) begin
          db_cnt_q[b] <= '0;
        end else if (db_cnt_q[b] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level_q[b]  <= sync2_q[b];
          db_cnt_q[b] <= '0;
        end else begin
          db_cnt_q[b] <= db_cnt_q[b] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; clear outranks start, start outranks lap
  always_comb begin
    state_d = state_q;
`ifdef CHRONO_LAP_EN
    snap_take_c = 1'b0;
`endif
    if (clear_p) begin
      state_d = S_IDLE;
    end else if (start_p) begin
      case (state_q)
        S_RUN, S_LAP: state_d = S_PAUSE;
        default:      state_d = S_RUN;
      endcase
`ifdef CHRONO_LAP_EN
    end else if (lap_p) begin
      if (state_q == S_RUN) begin
        state_d     = S_LAP;
        snap_take_c = 1'b1;
      end else if (state_q == S_LAP) begin
        state_d = S_RUN;
      end
`endif
    end
  end

  assign running_c = (state_q == S_RUN) || (state_q == S_LAP);
  assign tick_c    = running_c && (psc_q == PSC_W'(PRESCALE - 1));

  function automatic logic [3:0] digit_max(input int idx);
    // Tens of seconds and tens of minutes roll over after 5
    return ((idx == 3) || (idx == 5)) ? 4'd5 : 4'd9;
  endfunction

  // Ripple-carry BCD increment; carry out of the top digit marks the all-maximum value
  always_comb begin
    logic carry;
    cnt_inc_c = cnt_q;
    carry     = 1'b1;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (carry) begin
        if (cnt_q[i] == digit_max(i)) begin
          cnt_inc_c[i] = 4'd0;
        end else begin
          cnt_inc_c[i] = cnt_q[i] + 4'd1;
          carry        = 1'b0;
        end
      end
    end
    all_max_c = carry;
  end

  // Prescaler holds outside RUN/LAP so a pause keeps the sub-tick fraction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (clear_p) begin
      psc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (running_c) begin
        psc_q <= tick_c ? '0 : psc_q + PSC_W'(1);
      end
      if (tick_c) begin
        cnt_q <= cnt_inc_c;
        if (all_max_c) begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

`ifdef CHRONO_LAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_q <= '0;
    end else if (snap_take_c) begin
      snap_q <= cnt_q;
    end
  end

  assign lap_act_c = (state_q == S_LAP);
  assign disp_c    = lap_act_c ? snap_q : cnt_q;
`else
  assign lap_act_c = 1'b0;
  assign disp_c    = cnt_q;
`endif

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Registered display and LED drivers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg  <= {N_DIGITS{7'b1000000}};
      leds <= 3'b000;
    end else begin
      for (int i = 0; i < int'(N_DIGITS); i++) begin
        seg[7*i +: 7] <= seg_decode(disp_c[i]);
      end
      leds <= {ovf_q, lap_act_c, running_c};
    end
  end

endmodule

// File: tb/tb_chrono_core.sv
// tb_chrono_core: randomized button stimulus against a time-in-centiseconds reference model,
// plus a 4-digit, prescale-1 instance that exercises the overflow wrap quickly.

module tb_chrono_core;

  localparam int unsigned CLK_HZ  = 1000;
  localparam int unsigned TICK_HZ = 100;
  localparam int unsigned N_DIG   = 6;
  localparam int unsigned DEB     = 4;
  localparam int          PRESC   = int'(CLK_HZ / TICK_HZ);
  localparam int          WRAP_T  = 360000;

`ifdef CHRONO_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  localparam logic [41:0] ZERO6 = {6{7'b1000000}};
  localparam logic [27:0] ZERO4 = {4{7'b1000000}};

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_start, btn_lap, btn_clear;
  logic [41:0] seg;
  logic [2:0]  leds;
  logic        w_start, w_lap, w_clear;
  logic [27:0] w_seg;
  logic [2:0]  w_leds;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  chrono_core #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .N_DIGITS(N_DIG), .DEBOUNCE_CYCLES(DEB)
  ) u_dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_lap(btn_lap),
    .btn_clear(btn_clear), .seg(seg), .leds(leds)
  );

  chrono_core #(
    .CLK_HZ(100), .TICK_HZ(100), .N_DIGITS(4), .DEBOUNCE_CYCLES(DEB)
  ) u_dut_wrap (
    .clk(clk), .rst(rst), .btn_start(w_start), .btn_lap(w_lap),
    .btn_clear(w_clear), .seg(w_seg), .leds(w_leds)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg7(input int d);
    case (d)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // mm:ss.cc from an elapsed time in centiseconds
  function automatic logic [41:0] disp6(input int t);
    int cs, s, m;
    cs = t % 100;
    s  = (t / 100) % 60;
    m  = (t / 6000) % 60;
    return {seg7(m / 10), seg7(m % 10), seg7(s / 10), seg7(s % 10), seg7(cs / 10), seg7(cs % 10)};
  endfunction

  // Reference model: 0 idle, 1 run, 2 pause, 3 lap; time kept as an integer count of ticks
  int          m_state, m_t, m_snap, m_psc;
  bit          m_ovf;
  bit [2:0]    m_s1, m_s2, m_lvl, m_lvlq, m_press;
  int          m_run [3];
  logic [41:0] m_seg;
  logic [2:0]  m_leds;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_t = 0; m_snap = 0; m_psc = 0; m_ovf = 1'b0;
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvlq = '0; m_press = '0;
      for (int b = 0; b < 3; b++) m_run[b] = 0;
      m_seg  = disp6(0);
      m_leds = 3'b000;
    end else begin
      bit [2:0] raw;
      bit       running, tick;
      int       t_old;
      raw     = {btn_clear, btn_lap, btn_start};
      m_seg   = disp6((m_state == 3) ? m_snap : m_t);
      m_leds  = {m_ovf, m_state == 3, (m_state == 1) || (m_state == 3)};
      running = (m_state == 1) || (m_state == 3);
      tick    = running && (m_psc == PRESC - 1);
      t_old   = m_t;
      if (m_press[2]) begin
        m_state = 0; m_t = 0; m_psc = 0; m_ovf = 1'b0;
      end else begin
        if (running) m_psc = tick ? 0 : m_psc + 1;
        if (tick) begin
          m_t = m_t + 1;
          if (m_t == WRAP_T) begin
            m_t   = 0;
            m_ovf = 1'b1;
          end
        end
        if (m_press[0]) begin
          m_state = running ? 2 : 1;
        end else if (m_press[1] && LAP_EN) begin
          if (m_state == 1) begin
            m_state = 3;
            m_snap  = t_old;
          end else if (m_state == 3) begin
            m_state = 1;
          end
        end
      end
      for (int b = 0; b < 3; b++) begin
        m_press[b] = m_lvl[b] & ~m_lvlq[b];
        m_lvlq[b]  = m_lvl[b];
        if (m_s2[b] != m_lvl[b]) begin
          m_run[b]++;
          if (m_run[b] == DEB) begin
            m_lvl[b] = m_s2[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
      end
    end
  end

  always @(negedge clk) begin
    check("seg_vs_model", 64'(seg), 64'(m_seg));
    check("leds_vs_model", 64'(leds), 64'(m_leds));
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit s, input bit l, input bit c, input int hold);
    @(negedge clk);
    btn_start = s; btn_lap = l; btn_clear = c;
    repeat (hold) @(negedge clk);
    btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
  endtask

  initial begin
    logic [27:0] w_max, w_one;
    bit          found;
    rst = 1'b1;
    btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
    w_start = 1'b0; w_lap = 1'b0; w_clear = 1'b0;
    w_max = {seg7(5), seg7(9), seg7(9), seg7(9)};
    w_one = {seg7(0), seg7(0), seg7(0), seg7(1)};

    idle(3);
    check("reset_seg", 64'(seg), 64'(ZERO6));
    check("reset_leds", 64'(leds), 64'(3'b000));
    rst = 1'b0;
    idle(3);

    press(1'b1, 1'b0, 1'b0, 10);
    idle(10);
    check("start_leds", 64'(leds), 64'(3'b001));
    idle(1500);

    press(1'b1, 1'b0, 1'b0, 10);
    idle(10);
    check("pause_leds", 64'(leds), 64'(3'b000));
    idle(500);
    press(1'b1, 1'b0, 1'b0, 10);
    idle(10);
    check("resume_leds", 64'(leds), 64'(3'b001));

    press(1'b1, 1'b0, 1'b0, 3);
    idle(20);
    check("glitch_leds", 64'(leds), 64'(3'b001));

    press(1'b0, 1'b1, 1'b0, 10);
    idle(10);
    check("lap_leds", 64'(leds), 64'(LAP_EN ? 3'b011 : 3'b001));
    idle(300);
    press(1'b0, 1'b1, 1'b0, 10);
    idle(10);
    check("lap_exit_leds", 64'(leds), 64'(3'b001));

    press(1'b1, 1'b0, 1'b1, 10);
    idle(10);
    check("start_clear_leds", 64'(leds), 64'(3'b000));
    check("start_clear_seg", 64'(seg), 64'(ZERO6));

    for (int k = 0; k < 120; k++) begin
      bit s, l, c;
      s = ($urandom_range(0, 2) == 0);
      l = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 9) == 0);
      press(s, l, c, int'($urandom_range(1, 12)));
      idle(int'($urandom_range(1, 40)));
    end

    press(1'b0, 1'b0, 1'b1, 10);
    idle(10);
    press(1'b1, 1'b0, 1'b0, 10);
    idle(100);
    check("prereset_leds", 64'(leds), 64'(3'b001));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_seg", 64'(seg), 64'(ZERO6));
    check("async_rst_leds", 64'(leds), 64'(3'b000));
    idle(3);
    rst = 1'b0;
    idle(5);
    check("rst_release_seg", 64'(seg), 64'(ZERO6));
    check("rst_release_leds", 64'(leds), 64'(3'b000));

    @(negedge clk);
    w_start = 1'b1;
    repeat (10) @(negedge clk);
    w_start = 1'b0;
    found = 1'b0;
    for (int k = 0; (k < 7000) && !found; k++) begin
      @(negedge clk);
      if (w_seg == w_max) found = 1'b1;
    end
    check("wrap_reach_max", 64'(found), 64'(1'b1));
    if (found) begin
      @(negedge clk);
      check("wrap_seg_zero", 64'(w_seg), 64'(ZERO4));
      check("wrap_leds_ovf", 64'(w_leds), 64'(3'b101));
      @(negedge clk);
      check("wrap_continues", 64'(w_seg), 64'(w_one));
    end
    @(negedge clk);
    w_clear = 1'b1;
    repeat (10) @(negedge clk);
    w_clear = 1'b0;
    idle(10);
    check("wrap_clear_leds", 64'(w_leds), 64'(3'b000));
    check("wrap_clear_seg", 64'(w_seg), 64'(ZERO4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
